// File: rtl/dsp_pipe_chain.sv
// dsp_pipe_chain: per-channel clock-enabled delay line with runtime tap.
// Option macro DSP_PIPE_ZERO_INVALID_EN: zero dout when selected valid is 0.
module dsp_pipe_chain #(
  parameter int WIDTH    = 18,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2,
  localparam int SW      = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sclr_i,
  input  logic [CHANNELS-1:0]       ce_i,
  input  logic [CHANNELS*WIDTH-1:0] din_i,
  input  logic [CHANNELS-1:0]       din_vld_i,
  input  logic [CHANNELS*SW-1:0]    tap_i,
  output logic [CHANNELS*WIDTH-1:0] dout_o,
  output logic [CHANNELS-1:0]       dout_vld_o,
  output logic [CHANNELS-1:0]       tap_err_o
);

  localparam logic [SW-1:0] DMAX = SW'(DEPTH);

  logic [CHANNELS-1:0][DEPTH-1:0][WIDTH-1:0] s_q, s_d;
  logic [CHANNELS-1:0][DEPTH-1:0]            v_q, v_d;
  logic [CHANNELS-1:0]                       err_q, err_d;
  logic [SW-1:0]                             tsel;

  // Next state: clear beats shift; shift only on the channel's enable.
  always_comb begin
    s_d   = s_q;
    v_d   = v_q;
    err_d = err_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sclr_i) begin
        s_d[c]   = '0;
        v_d[c]   = '0;
        err_d[c] = 1'b0;
      end else begin
        if (ce_i[c]) begin
          s_d[c][0] = din_i[c*WIDTH +: WIDTH];
          v_d[c][0] = din_vld_i[c];
          for (int k = 1; k < DEPTH; k++) begin
            s_d[c][k] = s_q[c][k-1];
            v_d[c][k] = v_q[c][k-1];
          end
        end
        if (tap_i[c*SW +: SW] > DMAX) begin
          err_d[c] = 1'b1;
        end
      end
    end
  end

  // Stage, valid-shadow and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q   <= '0;
      v_q   <= '0;
      err_q <= '0;
    end else begin
      s_q   <= s_d;
      v_q   <= v_d;
      err_q <= err_d;
    end
  end

  // Tap mux: bypass at 0, stage tap-1 otherwise, clamp past the end.
  always_comb begin
    dout_o     = '0;
    dout_vld_o = '0;
    tsel       = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      tsel = tap_i[c*SW +: SW];
      if (tsel == '0) begin
        dout_o[c*WIDTH +: WIDTH] = din_i[c*WIDTH +: WIDTH];
        dout_vld_o[c]            = din_vld_i[c];
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (tsel == SW'(k + 1) ||
              (k == DEPTH - 1 && tsel > DMAX)) begin
            dout_o[c*WIDTH +: WIDTH] = s_q[c][k];
            dout_vld_o[c]            = v_q[c][k];
          end
        end
      end
`ifdef DSP_PIPE_ZERO_INVALID_EN
      if (!dout_vld_o[c]) begin
        dout_o[c*WIDTH +: WIDTH] = '0;
      end
`else
`endif
    end
  end

  assign tap_err_o = err_q;

endmodule

// File: tb/tb_dsp_pipe_chain.sv
// tb_dsp_pipe_chain: directed + random stimulus against a
// history-queue model of the selectable-latency pipe.
module tb_dsp_pipe_chain;
  localparam int W  = 18;
  localparam int D  = 4;
  localparam int CH = 2;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            sclr_i;
  logic [CH-1:0]   ce_i;
  logic [CH*W-1:0] din_i;
  logic [CH-1:0]   din_vld_i;
  logic [CH*SW-1:0] tap_i;
  logic [CH*W-1:0] dout_o;
  logic [CH-1:0]   dout_vld_o;
  logic [CH-1:0]   tap_err_o;

  int checks = 0;
  int errors = 0;

  dsp_pipe_chain #(.WIDTH(W), .DEPTH(D), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .sclr_i(sclr_i), .ce_i(ce_i),
    .din_i(din_i), .din_vld_i(din_vld_i), .tap_i(tap_i),
    .dout_o(dout_o), .dout_vld_o(dout_vld_o), .tap_err_o(tap_err_o)
  );

  always #5 clk = ~clk;

  // Model: every sample accepted since the last clear, oldest first.
  logic [W-1:0] md[CH][$];
  logic         mv[CH][$];
  logic [CH-1:0] merr = '0;

  // Model update on each edge (and immediately on async reset).
  always @(posedge clk or posedge rst) begin
    if (rst || sclr_i) begin
      for (int c = 0; c < CH; c++) begin
        md[c].delete();
        mv[c].delete();
      end
      merr <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (ce_i[c]) begin
          md[c].push_back(din_i[c*W +: W]);
          mv[c].push_back(din_vld_i[c]);
          if (md[c].size() > 16) begin
            void'(md[c].pop_front());
            void'(mv[c].pop_front());
          end
        end
        if (int'(tap_i[c*SW +: SW]) > D) merr[c] <= 1'b1;
      end
    end
  end

  task automatic exp_out(input int c, output logic [W-1:0] d,
                         output logic v);
    int t;
    int n;
    int sz;
    t  = int'(tap_i[c*SW +: SW]);
    sz = md[c].size();
    if (t == 0) begin
      d = din_i[c*W +: W];
      v = din_vld_i[c];
    end else begin
      n = (t > D) ? D : t;
      if (n <= sz) begin
        d = md[c][sz-n];
        v = mv[c][sz-n];
      end else begin
        d = '0;
        v = 1'b0;
      end
    end
`ifdef DSP_PIPE_ZERO_INVALID_EN
    if (!v) d = '0;
`else
`endif
  endtask

  task automatic chk(input string nm, input int c,
                     input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s ch%0d got %h expected %h at %0t",
               nm, c, got, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [W-1:0] ed;
    logic         ev;
    for (int c = 0; c < CH; c++) begin
      exp_out(c, ed, ev);
      chk("dout", c, dout_o[c*W +: W], ed);
      chk("dout_vld", c, W'(dout_vld_o[c]), W'(ev));
      chk("tap_err", c, W'(tap_err_o[c]), W'(merr[c]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tap(input int c, input int v);
    tap_i[c*SW +: SW] = SW'(v);
  endtask

  initial begin
    rst = 1'b1;
    sclr_i = 1'b0;
    ce_i = '0;
    din_i = '0;
    din_vld_i = '0;
    tap_i = '0;
    set_tap(0, 4);
    tick();
    tick();
    chk("rst_dout", 0, dout_o[0 +: W], 18'h0);
    chk("rst_vld", 0, W'(dout_vld_o[0]), 18'h0);
    chk("rst_err", 0, W'(tap_err_o), 18'h0);
    rst = 1'b0;
    ce_i = 2'b11;
    din_vld_i[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din_i[0 +: W] = W'(32'hA0 + i);
      tick();
    end
    chk("fill_dout", 0, dout_o[0 +: W], 18'h000A0);
    chk("fill_vld", 0, W'(dout_vld_o[0]), 18'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_dout", 0, dout_o[0 +: W], 18'h0);
    chk("async_rst_vld", 0, W'(dout_vld_o[0]), 18'h0);
    chk("async_rst_err", 0, W'(tap_err_o[0]), 18'h0);
    tick();
    rst = 1'b0;
    ce_i = '0;
    din_i = '0;
    din_vld_i = '0;

    set_tap(0, 0);
    ce_i = 2'b11;
    din_i[0 +: W] = 18'h00011;
    din_vld_i[0] = 1'b1;
    #1;
    chk("bypass_dout", 0, dout_o[0 +: W], 18'h00011);
    chk("bypass_vld", 0, W'(dout_vld_o[0]), 18'h1);
    set_tap(0, 3);
    tick();
    din_i[0 +: W] = '0;
    din_vld_i[0] = 1'b0;
    chk("lat_e0_vld", 0, W'(dout_vld_o[0]), 18'h0);
    tick();
    chk("lat_e1_vld", 0, W'(dout_vld_o[0]), 18'h0);
    tick();
    chk("lat_e2_dout", 0, dout_o[0 +: W], 18'h00011);
    chk("lat_e2_vld", 0, W'(dout_vld_o[0]), 18'h1);
    tick();
    chk("lat_e3_vld", 0, W'(dout_vld_o[0]), 18'h0);

    set_tap(1, 2);
    din_i[W +: W] = 18'h3FFFF;
    din_vld_i[1] = 1'b1;
    din_vld_i[0] = 1'b1;
    din_i[0 +: W] = 18'h00200;
    tick();
    ce_i[1] = 1'b0;
    din_i[W +: W] = '0;
    din_vld_i[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din_i[0 +: W] = W'(32'h201 + i);
      chk("stall_vld", 1, W'(dout_vld_o[1]), 18'h0);
      tick();
    end
    chk("stall_hold_vld", 1, W'(dout_vld_o[1]), 18'h0);
    ce_i[1] = 1'b1;
    tick();
    chk("stall_dout", 1, dout_o[W +: W], 18'h3FFFF);
    chk("stall_vld1", 1, W'(dout_vld_o[1]), 18'h1);

    ce_i = 2'b01;
    set_tap(0, 4);
    din_vld_i[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din_i[0 +: W] = W'(32'h100 + i);
      tick();
    end
    ce_i = '0;
    set_tap(0, 7);
    #1;
    chk("oob_dout", 0, dout_o[0 +: W], 18'h00100);
    chk("oob_vld", 0, W'(dout_vld_o[0]), 18'h1);
    chk("oob_err_pre", 0, W'(tap_err_o[0]), 18'h0);
    tick();
    set_tap(0, 2);
    chk("oob_err_set", 0, W'(tap_err_o[0]), 18'h1);
    tick();
    chk("oob_err_sticky", 0, W'(tap_err_o[0]), 18'h1);

    sclr_i = 1'b1;
    ce_i = 2'b11;
    din_i[0 +: W] = 18'h12345;
    din_vld_i[0] = 1'b1;
    tick();
    sclr_i = 1'b0;
    ce_i = '0;
    din_vld_i = '0;
    set_tap(0, 1);
    set_tap(1, 1);
    chk("sclr_dout", 0, dout_o[0 +: W], 18'h0);
    chk("sclr_vld", 0, W'(dout_vld_o[0]), 18'h0);
    chk("sclr_err", 0, W'(tap_err_o[0]), 18'h0);
    chk("sclr_dout1", 1, dout_o[W +: W], 18'h0);

    ce_i = 2'b01;
    din_i[0 +: W] = 18'h2AAAA;
    din_vld_i[0] = 1'b0;
    tick();
    ce_i = '0;
`ifdef DSP_PIPE_ZERO_INVALID_EN
    chk("zinv_dout", 0, dout_o[0 +: W], 18'h0);
`else
    chk("raw_dout", 0, dout_o[0 +: W], 18'h2AAAA);
`endif
    chk("inv_vld", 0, W'(dout_vld_o[0]), 18'h0);

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      sclr_i = ($urandom_range(0, 31) == 0);
      ce_i = CH'($urandom);
      din_vld_i = CH'($urandom);
      for (int c = 0; c < CH; c++) begin
        din_i[c*W +: W] = W'($urandom);
        if ($urandom_range(0, 9) == 0)
          set_tap(c, int'($urandom_range(5, 7)));
        else
          set_tap(c, int'($urandom_range(0, 4)));
      end
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_pipe_chain.md
# dsp_pipe_chain

Multi-channel, runtime-selectable-latency pipeline register for the DSP slice datapath. Each channel carries a chain of DEPTH clock-enabled registers with a parallel valid-bit shadow. A per-channel tap select chooses bypass (0 cycles) or any stage 1..DEPTH as the output. It generalises the single-stage register/bypass mux used on the slice input and output ports: multi-stage latency, multiple channels, valid tracking, sync clear and out-of-range tap detection.

## Interface
- WIDTH, 18, data width per channel
- DEPTH, 4, register stages per channel (1..15)
- CHANNELS, 2, independent channels (1..8)
- SW (localparam), $clog2(DEPTH+1), tap-select width per channel
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- sclr  input  1  synchronous clear, all channels
- ce  input  CHANNELS  per-channel clock enable
- din  input  CHANNELS*WIDTH  channel c at [c*WIDTH +: WIDTH]
- din_vld  input  CHANNELS  input valid per channel
- tap  input  CHANNELS*SW  latency select per channel, channel c at [c*SW +: SW]
- dout  output  CHANNELS*WIDTH  selected data per channel
- dout_vld  output  CHANNELS  selected valid per channel
- tap_err  output  CHANNELS  sticky out-of-range tap flag

## Operation
- Per channel c, stages s[0..DEPTH-1] of WIDTH bits, plus valid bits v[0..DEPTH-1].
- Priority per edge: rst (async) > sclr > ce[c] > hold.
- When ce[c]=1: s[0]<=din_c, v[0]<=din_vld[c]; s[k]<=s[k-1], v[k]<=v[k-1] for k=1..DEPTH-1.
- When ce[c]=0: channel c holds all stages and valid bits. Other channels are unaffected.
- sclr=1: all s and v of all channels clear to 0, regardless of ce.
- Output select, combinational on tap_c:
  - tap_c=0: dout_c=din_c, dout_vld[c]=din_vld[c] (bypass).
  - 1<=tap_c<=DEPTH: dout_c=s[tap_c-1], dout_vld[c]=v[tap_c-1].
  - tap_c>DEPTH: clamp to s[DEPTH-1]/v[DEPTH-1]. tap_err[c] is set on the next edge.
- tap_err[c] is registered and sticky. It is cleared only by rst or sclr. sclr wins over a simultaneous set.
- tap may change on any cycle. The new selection applies combinationally the same cycle, with no pipeline flush.
- No arithmetic: data passes bit-exact, unsigned/signed agnostic.

## Timing
- Reset values: all s=0, all v=0, tap_err=0. Consequently dout=0 and dout_vld=0 for any tap≠0. For tap=0, outputs follow din/din_vld even during rst.
- Latency for tap_c=N≥1: a sample accepted on edge t (ce high) appears on dout after edge t+N−1. That is N enabled edges from input to visibility, counting only edges with ce[c]=1.
- ce gaps stretch latency: stalled cycles do not advance data or valid.
- rst asserted mid-stream discards all in-flight samples immediately, without waiting for clk. Deassertion is synchronised externally.
- sclr and ce high on the same edge: clear wins, so din on that edge is dropped.
- tap_err rises one edge after the first cycle tap_c>DEPTH is seen.

## Configuration
- DSP_PIPE_ZERO_INVALID_EN defined: dout_c is forced to 0 whenever the selected valid bit (dout_vld[c]) is 0. This applies to the bypass path too.
- Not defined: dout_c carries the raw selected stage/din contents regardless of valid. This gives the smaller mux.

## Test plan
- Reset: apply rst mid-cycle with a filled pipe (CH0 tap=4). dout_0=0 and dout_vld[0]=0 immediately, before the next clk; tap_err=0.
- Latency: CH0 tap=3, ce=1, drive din=0x00011 (vld=1) for one cycle, then vld=0. Value 0x00011 with vld=1 appears on dout_0 for exactly one cycle, two edges after the capture edge. At tap=0 it appears the same cycle.
- Stall: CH1 tap=2, push 0x3FFFF; drop ce[1] for 3 cycles after the first edge. dout_1 shows 0x3FFFF only after the second enabled edge. CH0 keeps streaming unaffected.
- Sync clear: pipe full of vld=1 data; pulse sclr together with ce=1 and din=0x12345. All stages clear to 0, 0x12345 is not captured, and tap_err clears.
- Tap out of range (DEPTH=4): set tap_0=7 for one cycle. dout_0 equals s[3] that cycle, tap_err[0]=1 from the next edge, and it stays 1 after tap returns to 2 until sclr.
- Macro: with DSP_PIPE_ZERO_INVALID_EN, push din=0x2AAAA with vld=0 at tap=1: dout_0=0 after one edge. Without the macro: dout_0=0x2AAAA with dout_vld[0]=0.
